// File: rtl/axilite_slave_shim.sv
// AXI-Lite slave shim: buffers AW/W/AR, arbitrates read vs write round-robin, and issues single-cycle local-bus requests.
// Build macro AXILITE_SLV_TIMEOUT_EN enables a local-response timeout that returns an error response.
module axilite_slave_shim #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,

    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,

    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,

    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,

    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,

    output logic                  lcl_wr,
    output logic                  lcl_rd,
    output logic [ADDR_WIDTH-1:0] lcl_addr,
    output logic [31:0]           lcl_wdata,
    output logic [3:0]            lcl_wstrb,
    input  logic                  lcl_ack,
    input  logic                  lcl_dv,
    input  logic [31:0]           lcl_rdata,
    input  logic                  lcl_rsp,

    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        WR_RESP,
        RD_REQ,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t state, state_next;

    logic                  aw_full;
    logic                  w_full;
    logic                  ar_full;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic                  pref_wr;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic wr_elig, rd_elig, grant_wr, grant_rd;
    logic ack_hit, dv_hit, tmo_hit;
    logic rd_path;

    assign s_axi_awready = !aw_full;
    assign s_axi_wready  = !w_full;
    assign s_axi_arready = !ar_full;

    assign aw_hs = s_axi_awvalid && !aw_full;
    assign w_hs  = s_axi_wvalid && !w_full;
    assign ar_hs = s_axi_arvalid && !ar_full;
    assign b_hs  = (state == WR_RESP) && s_axi_bready;
    assign r_hs  = (state == RD_RESP) && s_axi_rready;

    // Eligibility looks through this cycle's handshakes so a request can issue right after capture.
    assign wr_elig  = (aw_full || aw_hs) && (w_full || w_hs);
    assign rd_elig  = ar_full || ar_hs;
    assign grant_wr = (state == IDLE) && wr_elig && (!rd_elig || pref_wr);
    assign grant_rd = (state == IDLE) && rd_elig && !grant_wr;

    assign ack_hit = (state == WR_WAIT) && lcl_ack;
    assign dv_hit  = (state == RD_WAIT) && lcl_dv;

    assign rd_path   = (state == RD_REQ) || (state == RD_WAIT) || (state == RD_RESP);
    assign lcl_addr  = rd_path ? ar_addr : aw_addr;
    assign lcl_wdata = w_data;
    assign lcl_wstrb = w_strb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            ar_full <= 1'b0;
            ar_addr <= '0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end else if (b_hs) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end else if (b_hs) begin
                w_full <= 1'b0;
            end
            if (ar_hs) begin
                ar_full <= 1'b1;
                ar_addr <= s_axi_araddr;
            end else if (r_hs) begin
                ar_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pref_wr <= 1'b1;
        end else begin
            state <= state_next;
            if (grant_wr) begin
                pref_wr <= 1'b0;
            end else if (grant_rd) begin
                pref_wr <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        lcl_wr       = 1'b0;
        lcl_rd       = 1'b0;
        s_axi_bvalid = 1'b0;
        s_axi_rvalid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_next = WR_REQ;
                end else if (grant_rd) begin
                    state_next = RD_REQ;
                end
            end
            WR_REQ: begin
                lcl_wr     = 1'b1;
                state_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (ack_hit || tmo_hit) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    state_next = IDLE;
                end
            end
            RD_REQ: begin
                lcl_rd     = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (dv_hit || tmo_hit) begin
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A real ack/dv takes priority over a timeout expiring in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_bresp <= 2'b00;
            s_axi_rresp <= 2'b00;
            s_axi_rdata <= '0;
        end else begin
            if (ack_hit) begin
                s_axi_bresp <= lcl_rsp ? 2'b10 : 2'b00;
            end else if ((state == WR_WAIT) && tmo_hit) begin
                s_axi_bresp <= 2'b10;
            end
            if (dv_hit) begin
                s_axi_rdata <= lcl_rdata;
                s_axi_rresp <= lcl_rsp ? 2'b10 : 2'b00;
            end else if ((state == RD_WAIT) && tmo_hit) begin
                s_axi_rdata <= TIMEOUT_RDATA;
                s_axi_rresp <= 2'b10;
            end
        end
    end

`ifdef AXILITE_SLV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_pulse;
    logic          unused_prot;

    assign tmo_hit     = ((state == WR_WAIT) || (state == RD_WAIT)) &&
                         (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo_pulse;
    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    // Counter is held at zero outside the wait states, so every wait starts from a clean count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= '0;
            tmo_pulse <= 1'b0;
        end else begin
            tmo_pulse <= tmo_hit && !ack_hit && !dv_hit;
            if ((state == WR_WAIT) || (state == RD_WAIT)) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = ^{s_axi_awprot, s_axi_arprot, TIMEOUT_RDATA, 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_axilite_slave_shim.sv
// Directed self-checking bench for axilite_slave_shim; timeout cases build only with AXILITE_SLV_TIMEOUT_EN.
module tb_axilite_slave_shim;

    localparam int AW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axi_awvalid, s_axi_awready;
    logic [AW-1:0] s_axi_awaddr;
    logic [2:0]    s_axi_awprot;
    logic          s_axi_wvalid, s_axi_wready;
    logic [31:0]   s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_bvalid, s_axi_bready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_arvalid, s_axi_arready;
    logic [AW-1:0] s_axi_araddr;
    logic [2:0]    s_axi_arprot;
    logic          s_axi_rvalid, s_axi_rready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          lcl_wr, lcl_rd;
    logic [AW-1:0] lcl_addr;
    logic [31:0]   lcl_wdata;
    logic [3:0]    lcl_wstrb;
    logic          lcl_ack, lcl_dv, lcl_rsp;
    logic [31:0]   lcl_rdata;
    logic          timeout_err;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    axilite_slave_shim #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awprot (s_axi_awprot),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arprot (s_axi_arprot),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .lcl_wr       (lcl_wr),
        .lcl_rd       (lcl_rd),
        .lcl_addr     (lcl_addr),
        .lcl_wdata    (lcl_wdata),
        .lcl_wstrb    (lcl_wstrb),
        .lcl_ack      (lcl_ack),
        .lcl_dv       (lcl_dv),
        .lcl_rdata    (lcl_rdata),
        .lcl_rsp      (lcl_rsp),
        .timeout_err  (timeout_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Each step lands 1 time unit after a rising edge: outputs settled, new inputs sampled at the next edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearInputs();
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awprot = 3'b111;
        s_axi_wvalid  = 1'b0; s_axi_wdata  = '0; s_axi_wstrb  = '0;
        s_axi_bready  = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arprot = 3'b101;
        s_axi_rready  = 1'b0;
        lcl_ack = 1'b0; lcl_dv = 1'b0; lcl_rsp = 1'b0; lcl_rdata = '0;
    endtask

    // Called in the WR_REQ cycle; finishes the write and returns in the following IDLE cycle.
    task automatic completeWrite(input string tag, input logic rsp);
        applyStimulus(1);
        lcl_ack = 1'b1; lcl_rsp = rsp;
        applyStimulus(1);
        lcl_ack = 1'b0; lcl_rsp = 1'b0;
        checkOutput({tag, " bvalid"}, 64'(s_axi_bvalid), 64'd1);
        checkOutput({tag, " bresp"}, 64'(s_axi_bresp), rsp ? 64'd2 : 64'd0);
        s_axi_bready = 1'b1;
        applyStimulus(1);
        s_axi_bready = 1'b0;
        checkOutput({tag, " bvalid after hs"}, 64'(s_axi_bvalid), 64'd0);
    endtask

    task automatic completeRead(input string tag, input logic [31:0] data);
        applyStimulus(1);
        lcl_dv = 1'b1; lcl_rdata = data;
        applyStimulus(1);
        lcl_dv = 1'b0; lcl_rdata = '0;
        checkOutput({tag, " rvalid"}, 64'(s_axi_rvalid), 64'd1);
        checkOutput({tag, " rdata"}, 64'(s_axi_rdata), 64'(data));
        s_axi_rready = 1'b1;
        applyStimulus(1);
        s_axi_rready = 1'b0;
        checkOutput({tag, " rvalid after hs"}, 64'(s_axi_rvalid), 64'd0);
    endtask

    task automatic writeTxn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic rsp);
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = data; s_axi_wstrb = strb;
        applyStimulus(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checkOutput({tag, " lcl_wr"}, 64'(lcl_wr), 64'd1);
        checkOutput({tag, " lcl_addr"}, 64'(lcl_addr), 64'(addr));
        checkOutput({tag, " lcl_wdata"}, 64'(lcl_wdata), 64'(data));
        checkOutput({tag, " lcl_wstrb"}, 64'(lcl_wstrb), 64'(strb));
        completeWrite(tag, rsp);
    endtask

    // Write and read both become eligible in the same IDLE cycle; wrFirst is the expected winner.
    task automatic arbRound(input string tag, input logic wrFirst, input logic [31:0] base);
        s_axi_awvalid = 1'b1; s_axi_awaddr = base;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = base ^ 32'h0F0F_0F0F; s_axi_wstrb = 4'h3;
        s_axi_arvalid = 1'b1; s_axi_araddr = base + 32'h4;
        applyStimulus(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        checkOutput({tag, " first lcl_wr"}, 64'(lcl_wr), 64'(wrFirst));
        checkOutput({tag, " first lcl_rd"}, 64'(lcl_rd), 64'(!wrFirst));
        if (wrFirst) completeWrite({tag, " wr"}, 1'b0);
        else         completeRead({tag, " rd"}, base + 32'h100);
        checkOutput({tag, " idle gap"}, 64'({lcl_wr, lcl_rd}), 64'd0);
        applyStimulus(1);
        checkOutput({tag, " second lcl_wr"}, 64'(lcl_wr), 64'(!wrFirst));
        checkOutput({tag, " second lcl_rd"}, 64'(lcl_rd), 64'(wrFirst));
        if (wrFirst) completeRead({tag, " rd"}, base + 32'h200);
        else         completeWrite({tag, " wr"}, 1'b0);
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        applyStimulus(2);

        checkOutput("rst ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'b111);
        checkOutput("rst valid", 64'({s_axi_bvalid, s_axi_rvalid, lcl_wr, lcl_rd, timeout_err}), 64'd0);
        checkOutput("rst resp", 64'({s_axi_bresp, s_axi_rresp}), 64'd0);
        checkOutput("rst rdata", 64'(s_axi_rdata), 64'd0);
        checkOutput("rst lcl bus", 64'({lcl_addr, lcl_wdata}), 64'd0);
        checkOutput("rst lcl_wstrb", 64'(lcl_wstrb), 64'd0);
        rst = 1'b0;
        applyStimulus(1);

        // Simultaneous requests straight after reset: write, read, write, read
        arbRound("arb1", 1'b1, 32'h0000_1000);
        arbRound("arb2", 1'b1, 32'h0000_2000);

        // Test 1: AW in cycle 0, W in cycle 3, ack in cycle 7
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_0010;
        applyStimulus(1);
        s_axi_awvalid = 1'b0;
        checkOutput("t1 awready after aw", 64'(s_axi_awready), 64'd0);
        applyStimulus(2);
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
        checkOutput("t1 no wr before w", 64'(lcl_wr), 64'd0);
        applyStimulus(1);
        s_axi_wvalid = 1'b0;
        checkOutput("t1 lcl_wr c4", 64'(lcl_wr), 64'd1);
        checkOutput("t1 lcl_addr", 64'(lcl_addr), 64'h10);
        checkOutput("t1 lcl_wdata", 64'(lcl_wdata), 64'h1234_5678);
        checkOutput("t1 lcl_wstrb", 64'(lcl_wstrb), 64'hF);
        applyStimulus(1);
        checkOutput("t1 lcl_wr one cycle", 64'(lcl_wr), 64'd0);
        applyStimulus(2);
        lcl_ack = 1'b1; lcl_rsp = 1'b0;
        checkOutput("t1 bvalid c7", 64'(s_axi_bvalid), 64'd0);
        applyStimulus(1);
        lcl_ack = 1'b0;
        checkOutput("t1 bvalid c8", 64'(s_axi_bvalid), 64'd1);
        checkOutput("t1 bresp", 64'(s_axi_bresp), 64'd0);
        applyStimulus(1);
        checkOutput("t1 bvalid held", 64'(s_axi_bvalid), 64'd1);
        checkOutput("t1 wready held", 64'(s_axi_wready), 64'd0);
        s_axi_bready = 1'b1;
        applyStimulus(1);
        s_axi_bready = 1'b0;
        checkOutput("t1 bvalid cleared", 64'(s_axi_bvalid), 64'd0);
        checkOutput("t1 aw/w freed", 64'({s_axi_awready, s_axi_wready}), 64'b11);

        // Test 2: read with dv on the 3rd cycle after lcl_rd, rready withheld 5 cycles
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0020;
        applyStimulus(1);
        s_axi_arvalid = 1'b0;
        checkOutput("t2 lcl_rd", 64'(lcl_rd), 64'd1);
        checkOutput("t2 lcl_addr", 64'(lcl_addr), 64'h20);
        applyStimulus(3);
        lcl_dv = 1'b1; lcl_rdata = 32'hCAFE_F00D; lcl_rsp = 1'b1;
        checkOutput("t2 rvalid before dv", 64'(s_axi_rvalid), 64'd0);
        applyStimulus(1);
        lcl_dv = 1'b0; lcl_rdata = '0; lcl_rsp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t2 rvalid hold%0d", i), 64'(s_axi_rvalid), 64'd1);
            checkOutput($sformatf("t2 rdata hold%0d", i), 64'(s_axi_rdata), 64'hCAFE_F00D);
            checkOutput($sformatf("t2 rresp hold%0d", i), 64'(s_axi_rresp), 64'd2);
            checkOutput($sformatf("t2 arready hold%0d", i), 64'(s_axi_arready), 64'd0);
            applyStimulus(1);
        end
        checkOutput("t2 no timeout_err", 64'(timeout_err), 64'd0);
        s_axi_rready = 1'b1;
        applyStimulus(1);
        s_axi_rready = 1'b0;
        checkOutput("t2 rvalid cleared", 64'(s_axi_rvalid), 64'd0);
        checkOutput("t2 arready freed", 64'(s_axi_arready), 64'd1);

        // Lone write leaves the arbiter favouring read, so the next tie goes to read
        writeTxn("lone", 32'h0000_0030, 32'hA5A5_0001, 4'h1, 1'b0);
        arbRound("arb3", 1'b0, 32'h0000_3000);

        // Test 4: stray ack in IDLE, stray dv during WR_WAIT
        lcl_ack = 1'b1;
        applyStimulus(1);
        lcl_ack = 1'b0;
        checkOutput("t4 idle ack ignored", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_0040;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h0BAD_F00D; s_axi_wstrb = 4'hC;
        applyStimulus(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checkOutput("t4 lcl_wr", 64'(lcl_wr), 64'd1);
        applyStimulus(1);
        lcl_dv = 1'b1; lcl_rdata = 32'h5555_5555;
        applyStimulus(1);
        lcl_dv = 1'b0; lcl_rdata = '0;
        checkOutput("t4 dv ignored", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
        applyStimulus(1);
        checkOutput("t4 still waiting", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
        lcl_ack = 1'b1; lcl_rsp = 1'b1;
        applyStimulus(1);
        lcl_ack = 1'b0; lcl_rsp = 1'b0;
        checkOutput("t4 bvalid", 64'(s_axi_bvalid), 64'd1);
        checkOutput("t4 bresp err", 64'(s_axi_bresp), 64'd2);
        s_axi_bready = 1'b1;
        applyStimulus(1);
        s_axi_bready = 1'b0;
        checkOutput("t4 bvalid cleared", 64'(s_axi_bvalid), 64'd0);

        // Test 5: reset asserted while waiting for a write ack
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_0050;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h7777_8888; s_axi_wstrb = 4'h6;
        applyStimulus(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        applyStimulus(1);
        rst = 1'b1;
        #1;
        checkOutput("t5 rst ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'b111);
        checkOutput("t5 rst valid", 64'({s_axi_bvalid, s_axi_rvalid, lcl_wr, lcl_rd}), 64'd0);
        checkOutput("t5 rst lcl bus", 64'({lcl_addr, lcl_wdata}), 64'd0);
        checkOutput("t5 rst resp/rdata", 64'({s_axi_bresp, s_axi_rresp, s_axi_rdata}), 64'd0);
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(1);
        writeTxn("t5 post-rst", 32'h0000_0060, 32'h9999_AAAA, 4'hF, 1'b0);

`ifdef AXILITE_SLV_TIMEOUT_EN
        // Test 6: read with no dv times out after TMO cycles in RD_WAIT
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0070;
        applyStimulus(1);
        s_axi_arvalid = 1'b0;
        checkOutput("t6 lcl_rd", 64'(lcl_rd), 64'd1);
        applyStimulus(TMO);
        checkOutput("t6 no rvalid at expiry", 64'({s_axi_rvalid, timeout_err}), 64'd0);
        applyStimulus(1);
        checkOutput("t6 timeout_err", 64'(timeout_err), 64'd1);
        checkOutput("t6 rvalid", 64'(s_axi_rvalid), 64'd1);
        checkOutput("t6 rresp", 64'(s_axi_rresp), 64'd2);
        checkOutput("t6 rdata", 64'(s_axi_rdata), 64'hDEAD_BEEF);
        s_axi_rready = 1'b1;
        applyStimulus(1);
        s_axi_rready = 1'b0;
        checkOutput("t6 timeout_err one cycle", 64'(timeout_err), 64'd0);

        // dv arriving in the expiry cycle wins
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0074;
        applyStimulus(1);
        s_axi_arvalid = 1'b0;
        applyStimulus(TMO);
        lcl_dv = 1'b1; lcl_rdata = 32'h1111_2222; lcl_rsp = 1'b0;
        applyStimulus(1);
        lcl_dv = 1'b0; lcl_rdata = '0;
        checkOutput("t6b rvalid", 64'(s_axi_rvalid), 64'd1);
        checkOutput("t6b rresp", 64'(s_axi_rresp), 64'd0);
        checkOutput("t6b rdata", 64'(s_axi_rdata), 64'h1111_2222);
        checkOutput("t6b no timeout_err", 64'(timeout_err), 64'd0);
        s_axi_rready = 1'b1;
        applyStimulus(1);
        s_axi_rready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/axilite_slave_shim.md
Name: axilite_slave_shim

Overview:
AXI-Lite slave front end that turns AXI-Lite write and read transactions into single-cycle local-bus register requests. Typical use: behind the MMIO AXI-Lite master, in front of action or infrastructure register files. Only one transaction is in flight at a time, and read and write requests are arbitrated round-robin.

Parameters:
ADDR_WIDTH, 32, width of the AXI and local address.
TIMEOUT_CYCLES, 1024, cycles to wait for a local ack or dv before an error response (timeout build only).
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out read.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_axi_awvalid in 1 / s_axi_awready out 1 / s_axi_awaddr in ADDR_WIDTH / s_axi_awprot in 3 (ignored)  write address channel
s_axi_wvalid in 1 / s_axi_wready out 1 / s_axi_wdata in 32 / s_axi_wstrb in 4  write data channel
s_axi_bvalid out 1 / s_axi_bready in 1 / s_axi_bresp out 2  write response channel
s_axi_arvalid in 1 / s_axi_arready out 1 / s_axi_araddr in ADDR_WIDTH / s_axi_arprot in 3 (ignored)  read address channel
s_axi_rvalid out 1 / s_axi_rready in 1 / s_axi_rdata out 32 / s_axi_rresp out 2  read data channel
lcl_wr  out  1  one-cycle write strobe
lcl_rd  out  1  one-cycle read strobe
lcl_addr  out  ADDR_WIDTH  request address
lcl_wdata  out  32  write data
lcl_wstrb  out  4  byte enables
lcl_ack  in  1  write done
lcl_dv  in  1  read data valid
lcl_rdata  in  32  read data
lcl_rsp  in  1  error flag, valid with ack or dv (0 = good, 1 = bad)
timeout_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values:
  - All valid, strobe and pulse outputs are 0.
  - awready, wready and arready are 1.
  - bresp, rresp, rdata, lcl_addr, lcl_wdata and lcl_wstrb are 0.
  - FSM is in IDLE and the arbiter favours write.
- Address and data buffers:
  - Three one-entry registers: AW, W and AR.
  - Each ready output equals "its buffer is empty".
  - An entry is captured on valid && ready; AW and W are independent and either may arrive first.
  - The AW and W buffers are freed on the B handshake; the AR buffer is freed on the R handshake. Ready therefore rises the cycle after the handshake.
- FSM states: IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- IDLE:
  - Write is eligible when AW and W are both full; read is eligible when AR is full.
  - If both are eligible, grant the side opposite the last grant. The arbiter toggles on every grant.
- WR_REQ (one cycle): lcl_wr=1; lcl_addr, lcl_wdata and lcl_wstrb are driven from the buffers. Next state is WR_WAIT.
  - Latency: AW and W both captured at edge T gives lcl_wr high in cycle T+1.
- WR_WAIT: lcl_ack sampled at edge A moves to WR_RESP. At A+1, bvalid=1 and bresp = lcl_rsp ? 2'b10 : 2'b00.
- WR_RESP: hold bvalid, bresp until bready. On the handshake: bvalid=0, free AW and W, go to IDLE.
- RD_REQ (one cycle): lcl_rd=1, lcl_addr=AR buffer. Next state is RD_WAIT.
- RD_WAIT: on lcl_dv, capture lcl_rdata into rdata and set rresp = lcl_rsp ? 2'b10 : 2'b00. rvalid=1 next cycle (RD_RESP).
- RD_RESP: hold rvalid, rdata, rresp until rready. On the handshake: rvalid=0, free AR, go to IDLE.
- Stray strobes: lcl_ack outside WR_WAIT and lcl_dv outside RD_WAIT are ignored. With ack and dv together, only the one matching the current state counts.
- Address handling: awprot and arprot are ignored. Address is passed through unmodified, no range check.
- Reset mid-transaction: all state is dropped immediately and no response is generated. The local side must tolerate an abandoned request.

Optional Feature:
Macro AXILITE_SLV_TIMEOUT_EN.
- Defined:
  - A counter runs in WR_WAIT and RD_WAIT and clears on entry to either state.
  - If TIMEOUT_CYCLES cycles elapse with no ack/dv, the FSM goes to WR_RESP or RD_RESP with response 2'b10. A timed-out read returns rdata=TIMEOUT_RDATA.
  - timeout_err pulses for one cycle.
  - An ack or dv arriving in the same cycle as expiry wins (normal response).
  - A late ack or dv after a timeout is ignored; the local side must not respond after timeout.
- Undefined: no counter; the WAIT states wait indefinitely; timeout_err is tied to 0.

Test Plan:
1. Write: AW=0x0000_0010 at cycle 0, W=0x1234_5678 strb 0xF at cycle 3 -> lcl_wr at cycle 4 with addr 0x10 and data 0x1234_5678; ack with rsp=0 at cycle 7 -> bvalid at 8, bresp=00.
2. Read: AR=0x20, lcl_dv at the 3rd cycle after lcl_rd with rdata 0xCAFE_F00D, rsp=1 -> rvalid with rdata 0xCAFE_F00D, rresp=10. rready held low 5 cycles -> rvalid/rdata stable and arready stays 0 throughout.
3. Simultaneous write and read ready in IDLE right after reset -> lcl_wr issued first, then lcl_rd. Repeat -> order alternates (write, read, write, read).
4. Spurious lcl_ack in IDLE and lcl_dv during WR_WAIT -> no bvalid/rvalid generated; a subsequent real ack completes the write normally.
5. Reset asserted during WR_WAIT -> all outputs return to reset values the same cycle; awready=1; the next write completes normally.
6. (AXILITE_SLV_TIMEOUT_EN, TIMEOUT_CYCLES=16) read with no dv -> after 16 cycles timeout_err pulses, rresp=10, rdata=0xDEAD_BEEF. Repeat with dv in exactly the expiry cycle -> rresp=00 with real data.
